regfile_banked: RTL and testbench
=================================

Name: regfile_banked

Overview:
- Parametrised successor to the AVR-style core register file.
- Two read ports:
  - Port A: returns a register pair {R[a+1], R[a]} for any a, aligned or unaligned.
  - Port B: returns a single register.
- One write port, byte or word; word writes may be unaligned.
- Storage is block RAM, split into even and odd banks. Write-first forwarding hides the BRAM read-before-write behaviour.
- A post-reset clear engine zeroes every register, because BRAM contents cannot be reset.

Parameters:
- DW, 8, register width in bits.
- NREGS, 32, register count; even, >= 4.
- AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- busy  out  1  high while the clear engine runs; the core stalls on it.
- rd_a_addr  in  AW  port A register index.
- rd_a_data  out  2*DW  {R[a+1 mod NREGS], R[a]}, valid one cycle after the address.
- rd_b_addr  in  AW  port B register index.
- rd_b_data  out  DW  R[b], valid one cycle after the address.
- wr_en  in  1  write strobe.
- wr_word  in  1  1 = write two registers, 0 = write one byte.
- wr_addr  in  AW  destination index d.
- wr_data  in  2*DW  byte write uses [DW-1:0]; word write sends [DW-1:0] to R[d] and [2DW-1:DW] to R[d+1 mod NREGS].

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; port names are clk and reset.
  - Reset values: rd_a_data=0, rd_b_data=0, busy=1, clear index=0, state=CLEAR.
- Storage layout:
  - Even bank holds R[2i]; odd bank holds R[2i+1]; each is NREGS/2 deep.
  - Each bank is duplicated, one copy per read port, to give two reads and one write.
- Read latency is 1 cycle:
  - An address sampled at edge N appears on the data output after edge N.
  - Semantics are write-first: the result includes any write presented at edge N.
- Pair read on port A:
  - Even a: both banks are read at index a>>1.
  - Odd a: the odd bank is read at a>>1 and the even bank at ((a+1) mod NREGS)>>1.
  - a=NREGS-1 wraps, returning {R[0], R[NREGS-1]}.
  - The read lane select is registered alongside the RAM read.
- Forwarding:
  - Per output byte lane, the target register index is compared against the one or two registers written at the same edge.
  - On a match, the registered write byte replaces the RAM byte.
  - Writes from earlier edges are already in RAM, so only one stage of forwarding is needed.
- Word write at odd d:
  - R[d] goes to the odd bank at d>>1.
  - R[d+1] goes to the even bank at ((d+1) mod NREGS)>>1.
  - d=NREGS-1 writes R[NREGS-1] and R[0].
- State machine, CLEAR to RUN:
  - CLEAR: each cycle, write 0 to all four bank copies at the clear index and increment it. Leave CLEAR after index NREGS/2-1 has been written, i.e. NREGS/2 cycles.
  - RUN: busy=0; normal operation. The only exit is reset, which returns to CLEAR.
  - Reset is permitted at any time; mid-clear it restarts the clear from index 0.
- Behaviour while busy:
  - wr_en is ignored.
  - rd_a_data and rd_b_data are forced to 0.
  - The first read issued in the last CLEAR cycle returns 0s.
- Simultaneous read and write of the same register at the same edge returns the new data.

Optional Feature:
- Macro: REGFILE_CLEAR_EN.
- Defined: the clear engine exists; busy is high for reset plus NREGS/2 cycles.
- Undefined:
  - No FSM; busy is tied 0 and the banks are zero-initialised by simulation/bitstream init.
  - Reset clears only the output registers and forwarding registers.
  - A reset in RUN does not clear register contents.

Decomposition:
- Package regfile_pkg:
  - state enum {CLEAR, RUN};
  - function pair_next(addr, NREGS) for wrap-around;
  - function bank_index(addr).
- Sub-module regfile_bank:
  - simple dual-port RAM, NREGS/2 x DW;
  - one synchronous read, one write, read-before-write;
  - instantiated 4 times.
- Top level: clear FSM, write steering, lane select, forwarding muxes.

Test Plan:
- Clear engine: reset 1 cycle with default NREGS=32 → busy high for 16 cycles after reset falls; then read all pairs a=0..31 → every rd_a_data = 16'h0000.
- Same-cycle forwarding: byte write R5=8'hA7 with rd_b_addr=5 at the same edge → rd_b_data=8'hA7 next cycle. With rd_a_addr=4 at that edge → rd_a_data=16'hA7xx, where xx is the old R4.
- Unaligned word write: write word d=7 data 16'hBEEF → R7=8'hEF, R8=8'hBE. Then rd_a_addr=7 → 16'hBEEF; rd_b_addr=8 → 8'hBE.
- Wrap-around: word write d=31 data 16'h1234 → R31=8'h34, R0=8'h12. Then rd_a_addr=31 → 16'h1234.
- Write while busy: wr_en with d=3 data 8'h55 during CLEAR → ignored; R3 reads 0 after busy falls.
- Reset mid-clear: reset at clear cycle 7 → busy stays high and clear restarts at index 0, taking 16 more cycles. With REGFILE_CLEAR_EN undefined, busy is 0 throughout the first cycle after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and index helpers for the banked register file.
package regfile_pkg;

    // CLEAR zeroes the banks after reset; RUN is normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Register following addr, wrapping from nregs-1 back to 0.
    function automatic logic [31:0] pair_next(input logic [31:0] addr, input logic [31:0] nregs);
        return (addr + 32'd1 == nregs) ? 32'd0 : addr + 32'd1;
    endfunction

    // Row inside an even/odd bank holding register addr.
    function automatic logic [31:0] bank_index(input logic [31:0] addr);
        return addr >> 1;
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: simple dual-port block RAM, one synchronous read and one write.
// Read-before-write: a read and a write to the same row at one edge return the
// old contents; the top level forwards around this.
// Contents have no reset. With REGFILE_CLEAR_EN undefined the top relies on the
// simulator/bitstream initialising the array to zero.
module regfile_bank #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 16,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [IW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, sees the pre-write contents.
    always_ff @(posedge clk) begin
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/regfile_banked.sv
// regfile_banked: register file with a pair-read port A, a single-read port B
// and a byte/word write port, stored in even/odd BRAM banks (one copy per read
// port). Reads have one cycle of latency with write-first forwarding.
// Define REGFILE_CLEAR_EN to build the post-reset clear engine (busy output);
// without it busy is tied low and the banks rely on init values.
module regfile_banked
    import regfile_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    input  logic [AW-1:0] rd_a_addr,
    output logic [2*DW-1:0] rd_a_data,
    input  logic [AW-1:0] rd_b_addr,
    output logic [DW-1:0] rd_b_data,
    input  logic          wr_en,
    input  logic          wr_word,
    input  logic [AW-1:0] wr_addr,
    input  logic [2*DW-1:0] wr_data
);

    localparam int HD = NREGS / 2;
    localparam int IW = (HD > 1) ? $clog2(HD) : 1;

    logic          w_clearing;
    logic [IW-1:0] w_clr_idx;

`ifdef REGFILE_CLEAR_EN
    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_clr_idx;
    logic [IW-1:0] w_clr_idx_nxt;

    // Clear engine state and row counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Walk every bank row once, then hand over to RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clearing    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clearing    = 1'b1;
                w_clr_idx_nxt = r_clr_idx + IW'(1);
                if (r_clr_idx == IW'(HD - 1)) begin
                    w_state_nxt   = RUN;
                    w_clr_idx_nxt = '0;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign w_clr_idx = r_clr_idx;
    assign busy      = w_clearing;
`else
    assign w_clearing = 1'b0;
    assign w_clr_idx  = '0;
    assign busy       = 1'b0;
`endif

    // ---------------- write steering ----------------
    logic          w_wr_act;
    logic [AW-1:0] w_d1;
    logic [IW-1:0] w_d_idx;
    logic [IW-1:0] w_d1_idx;
    logic          w_ev_we;
    logic          w_od_we;
    logic [IW-1:0] w_ev_waddr;
    logic [IW-1:0] w_od_waddr;
    logic [DW-1:0] w_ev_wdata;
    logic [DW-1:0] w_od_wdata;

    assign w_wr_act = wr_en & ~w_clearing & ~reset;
    assign w_d1     = AW'(pair_next(32'(wr_addr), NREGS));
    assign w_d_idx  = IW'(bank_index(32'(wr_addr)));
    assign w_d1_idx = IW'(bank_index(32'(w_d1)));

    // Route R[d] and R[d+1] to whichever bank owns them; an odd d puts the
    // upper byte into the even bank one row further on (or row 0 on wrap).
    always_comb begin
        w_ev_we    = 1'b0;
        w_od_we    = 1'b0;
        w_ev_waddr = w_d_idx;
        w_od_waddr = w_d_idx;
        w_ev_wdata = wr_data[DW-1:0];
        w_od_wdata = wr_data[2*DW-1:DW];
        if (w_clearing) begin
            w_ev_we    = 1'b1;
            w_od_we    = 1'b1;
            w_ev_waddr = w_clr_idx;
            w_od_waddr = w_clr_idx;
            w_ev_wdata = '0;
            w_od_wdata = '0;
        end else if (w_wr_act) begin
            if (wr_addr[0]) begin
                w_od_we    = 1'b1;
                w_od_wdata = wr_data[DW-1:0];
                w_ev_we    = wr_word;
                w_ev_waddr = w_d1_idx;
                w_ev_wdata = wr_data[2*DW-1:DW];
            end else begin
                w_ev_we    = 1'b1;
                w_od_we    = wr_word;
            end
        end
    end

    // ---------------- read addressing ----------------
    logic [AW-1:0] w_a1;
    logic [IW-1:0] w_a_ev_raddr;
    logic [IW-1:0] w_a_od_raddr;
    logic [IW-1:0] w_b_raddr;
    logic [DW-1:0] w_a_ev_q;
    logic [DW-1:0] w_a_od_q;
    logic [DW-1:0] w_b_ev_q;
    logic [DW-1:0] w_b_od_q;

    assign w_a1         = AW'(pair_next(32'(rd_a_addr), NREGS));
    assign w_a_ev_raddr = rd_a_addr[0] ? IW'(bank_index(32'(w_a1)))
                                       : IW'(bank_index(32'(rd_a_addr)));
    assign w_a_od_raddr = IW'(bank_index(32'(rd_a_addr)));
    assign w_b_raddr    = IW'(bank_index(32'(rd_b_addr)));

    regfile_bank #(.DW(DW), .DEPTH(HD)) u_bank_ev_a (
        .clk(clk), .i_we(w_ev_we), .i_waddr(w_ev_waddr), .i_wdata(w_ev_wdata),
        .i_raddr(w_a_ev_raddr), .o_rdata(w_a_ev_q)
    );
    regfile_bank #(.DW(DW), .DEPTH(HD)) u_bank_od_a (
        .clk(clk), .i_we(w_od_we), .i_waddr(w_od_waddr), .i_wdata(w_od_wdata),
        .i_raddr(w_a_od_raddr), .o_rdata(w_a_od_q)
    );
    regfile_bank #(.DW(DW), .DEPTH(HD)) u_bank_ev_b (
        .clk(clk), .i_we(w_ev_we), .i_waddr(w_ev_waddr), .i_wdata(w_ev_wdata),
        .i_raddr(w_b_raddr), .o_rdata(w_b_ev_q)
    );
    regfile_bank #(.DW(DW), .DEPTH(HD)) u_bank_od_b (
        .clk(clk), .i_we(w_od_we), .i_waddr(w_od_waddr), .i_wdata(w_od_wdata),
        .i_raddr(w_b_raddr), .o_rdata(w_b_od_q)
    );

    // ---------------- output stage ----------------
    logic          r_rd_vld;
    logic [AW-1:0] r_a_lo_idx;
    logic [AW-1:0] r_a_hi_idx;
    logic [AW-1:0] r_b_idx;
    logic          r_fw_lo_en;
    logic          r_fw_hi_en;
    logic [AW-1:0] r_fw_lo_idx;
    logic [AW-1:0] r_fw_hi_idx;
    logic [DW-1:0] r_fw_lo_dat;
    logic [DW-1:0] r_fw_hi_dat;

    // Capture this edge's write so it can override the stale RAM byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld    <= 1'b0;
            r_fw_lo_en  <= 1'b0;
            r_fw_hi_en  <= 1'b0;
            r_fw_lo_idx <= '0;
            r_fw_hi_idx <= '0;
            r_fw_lo_dat <= '0;
            r_fw_hi_dat <= '0;
        end else begin
            r_rd_vld    <= ~w_clearing;
            r_fw_lo_en  <= w_wr_act;
            r_fw_hi_en  <= w_wr_act & wr_word;
            r_fw_lo_idx <= wr_addr;
            r_fw_hi_idx <= w_d1;
            r_fw_lo_dat <= wr_data[DW-1:0];
            r_fw_hi_dat <= wr_data[2*DW-1:DW];
        end
    end

    // Read targets travel with the RAM read; bit 0 doubles as the lane select.
    always_ff @(posedge clk) begin
        r_a_lo_idx <= rd_a_addr;
        r_a_hi_idx <= w_a1;
        r_b_idx    <= rd_b_addr;
    end

    logic [DW-1:0] w_a_lo;
    logic [DW-1:0] w_a_hi;
    logic [DW-1:0] w_b;

    // Lane select followed by per-lane write-first forwarding.
    always_comb begin
        w_a_lo = r_a_lo_idx[0] ? w_a_od_q : w_a_ev_q;
        w_a_hi = r_a_lo_idx[0] ? w_a_ev_q : w_a_od_q;
        w_b    = r_b_idx[0]    ? w_b_od_q : w_b_ev_q;
        if (r_fw_lo_en && (r_fw_lo_idx == r_a_lo_idx)) begin
            w_a_lo = r_fw_lo_dat;
        end else if (r_fw_hi_en && (r_fw_hi_idx == r_a_lo_idx)) begin
            w_a_lo = r_fw_hi_dat;
        end
        if (r_fw_lo_en && (r_fw_lo_idx == r_a_hi_idx)) begin
            w_a_hi = r_fw_lo_dat;
        end else if (r_fw_hi_en && (r_fw_hi_idx == r_a_hi_idx)) begin
            w_a_hi = r_fw_hi_dat;
        end
        if (r_fw_lo_en && (r_fw_lo_idx == r_b_idx)) begin
            w_b = r_fw_lo_dat;
        end else if (r_fw_hi_en && (r_fw_hi_idx == r_b_idx)) begin
            w_b = r_fw_hi_dat;
        end
    end

    assign rd_a_data = r_rd_vld ? {w_a_hi, w_a_lo} : '0;
    assign rd_b_data = r_rd_vld ? w_b : '0;

endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: directed and randomized checks of regfile_banked against
// an array model of the register file. Builds with or without REGFILE_CLEAR_EN.
module tb_regfile_banked;

    localparam int DW = 8;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int HD = N / 2;
`ifdef REGFILE_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          busy;
    logic [AW-1:0] rd_a_addr;
    logic [15:0]   rd_a_data;
    logic [AW-1:0] rd_b_addr;
    logic [7:0]    rd_b_data;
    logic          wr_en;
    logic          wr_word;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    regfile_banked #(.DW(DW), .NREGS(N)) dut (
        .clk(clk), .reset(reset), .busy(busy),
        .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
        .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
        .wr_en(wr_en), .wr_word(wr_word), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_fail;
    logic [7:0]  m_reg [N];
    int          busy_left;
    logic [15:0] exp_a;
    logic [7:0]  exp_b;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cycle(input bit rst, input int a, input int b, input bit we,
                         input bit word, input int d, input logic [15:0] data);
        reset     = rst;
        rd_a_addr = AW'(a);
        rd_b_addr = AW'(b);
        wr_en     = we;
        wr_word   = word;
        wr_addr   = AW'(d);
        wr_data   = data;
        @(posedge clk);
        if (rst) begin
            if (CLR_EN) begin
                busy_left = HD;
                for (int i = 0; i < N; i++) m_reg[i] = 8'h00;
            end
            exp_a = 16'h0000;
            exp_b = 8'h00;
        end else if (busy_left > 0) begin
            busy_left--;
            exp_a = 16'h0000;
            exp_b = 8'h00;
        end else begin
            if (we) begin
                m_reg[d] = data[7:0];
                if (word) m_reg[(d + 1) % N] = data[15:8];
            end
            exp_a = {m_reg[(a + 1) % N], m_reg[a]};
            exp_b = m_reg[b];
        end
        #1;
        check_val("rd_a", 32'(rd_a_data), 32'(exp_a));
        check_val("rd_b", 32'(rd_b_data), 32'(exp_b));
        check_val("busy", 32'(busy), 32'(busy_left > 0));
    endtask

    initial begin
        int nb;
        int d;
        int a;
        int b;
        int sel;
        bit rst;
        bit we;
        n_checks  = 0;
        n_fail    = 0;
        busy_left = 0;
        for (int i = 0; i < N; i++) m_reg[i] = 8'h00;
        reset = 1'b1; rd_a_addr = '0; rd_b_addr = '0;
        wr_en = 1'b0; wr_word = 1'b0; wr_addr = '0; wr_data = '0;

        cycle(1, 0, 0, 0, 0, 0, 16'h0000);
        cycle(1, 0, 0, 0, 0, 0, 16'h0000);

`ifdef REGFILE_CLEAR_EN
        // Partial clear with a dropped write, then reset in clear cycle 7.
        cycle(0, 3, 3, 1, 0, 3, 16'h0055);
        for (int i = 0; i < 6; i++) cycle(0, i, i, 0, 0, 0, 16'h0000);
        cycle(1, 0, 0, 0, 0, 0, 16'h0000);
        nb = 0;
        while (busy && nb < 40) begin
            cycle(0, 3, 3, (nb == 2), 0, 3, 16'h0055);
            nb++;
        end
        check_val("clear_len", 32'(nb), 32'(HD));
        cycle(0, 2, 3, 0, 0, 0, 16'h0000);
        check_val("busy_wr_dropped", 32'(rd_b_data), 32'h0);
`else
        // No clear engine: establish known contents, reading back through forwarding.
        for (int i = 0; i < N; i += 2) cycle(0, i, i, 1, 1, i, 16'h0000);
`endif

        for (int i = 0; i < N; i++) begin
            cycle(0, i, i, 0, 0, 0, 16'h0000);
            check_val("all_pairs_zero", 32'(rd_a_data), 32'h0);
        end

        cycle(0, 4, 5, 1, 0, 5, 16'h00A7);
        check_val("fwd_byte_b", 32'(rd_b_data), 32'h0000_00A7);
        check_val("fwd_byte_a", 32'(rd_a_data), 32'h0000_A700);

        cycle(0, 7, 8, 1, 1, 7, 16'hBEEF);
        check_val("fwd_word_a", 32'(rd_a_data), 32'h0000_BEEF);
        cycle(0, 7, 8, 0, 0, 0, 16'h0000);
        check_val("unaligned_a", 32'(rd_a_data), 32'h0000_BEEF);
        check_val("unaligned_b", 32'(rd_b_data), 32'h0000_00BE);

        cycle(0, 31, 0, 1, 1, 31, 16'h1234);
        cycle(0, 31, 0, 0, 0, 0, 16'h0000);
        check_val("wrap_a", 32'(rd_a_data), 32'h0000_1234);
        check_val("wrap_b", 32'(rd_b_data), 32'h0000_0012);

        // Random traffic biased towards reads that overlap the write.
        for (int k = 0; k < 3000; k++) begin
            d   = int'($urandom_range(N - 1));
            sel = int'($urandom_range(3));
            if (sel == 3) a = int'($urandom_range(N - 1));
            else          a = (d + N - 1 + sel) % N;
            sel = int'($urandom_range(3));
            if (sel == 3) b = int'($urandom_range(N - 1));
            else          b = (d + N - 1 + sel) % N;
            rst = ($urandom_range(299) == 0);
            we  = rst ? 1'b0 : 1'($urandom_range(1));
            cycle(rst, a, b, we, 1'($urandom_range(1)), d, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
